// File: rtl/cbc_encrypt.sv
// CBC-mode front end: XORs each plaintext block with the chaining value and
// drives one encrypt_iter core through its four-phase req/ack handshake.
`ifndef N_K
`define N_K 64
`endif
`ifndef N_B
`define N_B 64
`endif

module cbc_encrypt #(
    parameter int NK = `N_K,
    parameter int NB = `N_B
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [NK-1:0] k,
    input  logic [NB-1:0] iv,
    input  logic          iv_ld,
    input  logic [NB-1:0] m,
    input  logic          m_valid,
    output logic          m_ready,
    output logic [NB-1:0] c,
    output logic          c_valid,
    input  logic          c_ready,
    output logic [31:0]   n_blk,
    output logic          core_req,
    input  logic          core_ack,
    output logic [NK-1:0] core_k,
    output logic [NB-1:0] core_m,
    input  logic [NB-1:0] core_c
);

    // state | meaning
    // IDLE  | waiting for a plaintext block or an IV load
    // REQ   | core_req high, waiting for core_ack
    // REL   | core_req released, waiting for core_ack to drop
    // OUT   | ciphertext presented, waiting for c_ready
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] REL  = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    logic [1:0]    state_q,    state_d;
    logic [NB-1:0] chain_q,    chain_d;
    logic [NB-1:0] c_q,        c_d;
    logic [NK-1:0] core_k_q,   core_k_d;
    logic [NB-1:0] core_m_q,   core_m_d;
    logic [31:0]   n_blk_q,    n_blk_d;
    logic          core_req_q, core_req_d;
    logic          c_valid_q,  c_valid_d;

    assign m_ready  = (state_q == IDLE) & ~iv_ld & rst;
    assign c        = c_q;
    assign c_valid  = c_valid_q;
    assign n_blk    = n_blk_q;
    assign core_req = core_req_q;
    assign core_k   = core_k_q;
    assign core_m   = core_m_q;

    always_comb begin
        state_d    = state_q;
        chain_d    = chain_q;
        c_d        = c_q;
        core_k_d   = core_k_q;
        core_m_d   = core_m_q;
        n_blk_d    = n_blk_q;
        core_req_d = core_req_q;
        c_valid_d  = c_valid_q;
        case (state_q)
            IDLE: begin
                // an IV load takes priority over a waiting plaintext block
                if (iv_ld) begin
                    chain_d = iv;
                    n_blk_d = '0;
                end else if (m_valid) begin
                    core_m_d   = m ^ chain_q;
                    core_k_d   = k;
                    core_req_d = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                if (core_ack) begin
                    chain_d    = core_c;
                    c_d        = core_c;
                    core_req_d = 1'b0;
                    state_d    = REL;
                end
            end
            REL: begin
                if (!core_ack) begin
                    c_valid_d = 1'b1;
                    state_d   = OUT;
                end
            end
            OUT: begin
                if (c_ready) begin
                    c_valid_d = 1'b0;
                    n_blk_d   = n_blk_q + 32'd1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            chain_q    <= '0;
            c_q        <= '0;
            core_k_q   <= '0;
            core_m_q   <= '0;
            n_blk_q    <= '0;
            core_req_q <= 1'b0;
            c_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            chain_q    <= chain_d;
            c_q        <= c_d;
            core_k_q   <= core_k_d;
            core_m_q   <= core_m_d;
            n_blk_q    <= n_blk_d;
            core_req_q <= core_req_d;
            c_valid_q  <= c_valid_d;
        end
    end

endmodule
